// File: rtl/wb_commit_queue_pkg.sv
// Shared writeback definitions: write-enable codes and default widths.
// An entry is packed as {rd, data}, with rd in the upper bits.
package wb_commit_queue_pkg;
    localparam int WB_REG_AW_DEF = 5;
    localparam int WB_DATA_W_DEF = 32;
    localparam int WB_WE_W_DEF   = 4;
    localparam logic [3:0] WB_NONE = 4'd0;
    localparam logic [3:0] WB_REG  = 4'd2;
endpackage

// File: rtl/wb_lane_compact.sv
// Filters the three result lanes down to real register writes.
// Survivors are packed into consecutive outputs in age order, with lane0 first.
module wb_lane_compact
    import wb_commit_queue_pkg::*;
#(
    parameter int REG_AW = WB_REG_AW_DEF,
    parameter int DATA_W = WB_DATA_W_DEF,
    parameter int WE_W   = WB_WE_W_DEF,
    localparam int EW    = REG_AW + DATA_W
) (
    input  logic              i_fire,
    input  logic [REG_AW-1:0] i_rd0,
    input  logic [REG_AW-1:0] i_rd1,
    input  logic [REG_AW-1:0] i_rd2,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [WE_W-1:0]   i_we0,
    input  logic [WE_W-1:0]   i_we1,
    input  logic [WE_W-1:0]   i_we2,
    output logic [1:0]        o_push_cnt,
    output logic [EW-1:0]     o_ent0,
    output logic [EW-1:0]     o_ent1,
    output logic [EW-1:0]     o_ent2
);
    logic [2:0]    w_keep;
    logic [EW-1:0] w_in [3];

    // A write to x0 has no architectural effect, so it never takes a slot.
    assign w_keep[0] = i_fire && (i_we0 == WE_W'(WB_REG)) && (i_rd0 != '0);
    assign w_keep[1] = i_fire && (i_we1 == WE_W'(WB_REG)) && (i_rd1 != '0);
    assign w_keep[2] = i_fire && (i_we2 == WE_W'(WB_REG)) && (i_rd2 != '0);
    assign w_in[0]   = {i_rd0, i_data0};
    assign w_in[1]   = {i_rd1, i_data1};
    assign w_in[2]   = {i_rd2, i_data2};

    always_comb begin
        o_push_cnt = 2'd0;
        o_ent0     = '0;
        o_ent1     = '0;
        o_ent2     = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_keep[i]) begin
                case (o_push_cnt)
                    2'd0:    o_ent0 = w_in[i];
                    2'd1:    o_ent1 = w_in[i];
                    default: o_ent2 = w_in[i];
                endcase
                o_push_cnt = o_push_cnt + 2'd1;
            end
        end
    end
endmodule

// File: rtl/wb_commit_queue.sv
// Writeback commit queue: up to three results in per cycle, up to two register writes out.
// Writes drain in program order. A pending mask marks registers whose writes are still queued.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = WB_DATA_W_DEF,
    parameter int REG_AW = WB_REG_AW_DEF,
    parameter int WE_W   = WB_WE_W_DEF,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1,
    localparam int EW    = REG_AW + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd0,
    input  logic [REG_AW-1:0] in_rd1,
    input  logic [REG_AW-1:0] in_rd2,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [WE_W-1:0]   in_we0,
    input  logic [WE_W-1:0]   in_we1,
    input  logic [WE_W-1:0]   in_we2,
    output logic [REG_AW-1:0] rd1,
    output logic [DATA_W-1:0] wb_data1,
    output logic [WE_W-1:0]   wb_we1,
    output logic [REG_AW-1:0] rd2,
    output logic [DATA_W-1:0] wb_data2,
    output logic [WE_W-1:0]   wb_we2,
    output logic [31:0]       pend_mask,
    output logic [CW-1:0]     fifo_count
);
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_fire;
    logic [1:0]    w_push_cnt;
    logic [1:0]    w_pop_cnt;
    logic [EW-1:0] w_ent [3];
    logic [EW-1:0] w_ent_a;
    logic [EW-1:0] w_ent_b;
    logic [PW-1:0] w_off;

    // Handshake: a bundle transfers when in_valid && in_ready at a rising clk edge.
    // in_ready depends on the registered count only; pops in the same cycle give no credit.
    assign in_ready   = (r_count <= CW'(DEPTH - 3));
    assign w_fire     = in_valid && in_ready;
    assign fifo_count = r_count;
    assign w_pop_cnt  = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
    assign w_ent_a    = r_mem[r_head];
    assign w_ent_b    = r_mem[r_head + PW'(1)];

    wb_lane_compact #(.REG_AW(REG_AW), .DATA_W(DATA_W), .WE_W(WE_W)) u_compact (
        .i_fire     (w_fire),
        .i_rd0      (in_rd0),
        .i_rd1      (in_rd1),
        .i_rd2      (in_rd2),
        .i_data0    (in_data0),
        .i_data1    (in_data1),
        .i_data2    (in_data2),
        .i_we0      (in_we0),
        .i_we1      (in_we1),
        .i_we2      (in_we2),
        .o_push_cnt (w_push_cnt),
        .o_ent0     (w_ent[0]),
        .o_ent1     (w_ent[1]),
        .o_ent2     (w_ent[2])
    );

    // The younger entry goes on port 1, so the regfile's port-1 priority resolves a same-cycle WAW.
    always_comb begin
        rd1      = '0;
        wb_data1 = '0;
        wb_we1   = WE_W'(WB_NONE);
        rd2      = '0;
        wb_data2 = '0;
        wb_we2   = WE_W'(WB_NONE);
        if (r_count >= CW'(2)) begin
            {rd1, wb_data1} = w_ent_b;
            wb_we1          = WE_W'(WB_REG);
            {rd2, wb_data2} = w_ent_a;
            wb_we2          = WE_W'(WB_REG);
        end else if (r_count == CW'(1)) begin
            {rd1, wb_data1} = w_ent_a;
            wb_we1          = WE_W'(WB_REG);
        end
    end

    always_comb begin
        pend_mask = '0;
        w_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_head;
            if (CW'(w_off) < r_count)
                pend_mask[r_mem[i][EW-1 -: REG_AW]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            for (int j = 0; j < 3; j++)
                if (2'(j) < w_push_cnt)
                    r_mem[r_tail + PW'(j)] <= w_ent[j];
            r_head  <= r_head + PW'(w_pop_cnt);
            r_tail  <= r_tail + PW'(w_push_cnt);
            r_count <= r_count + CW'(w_push_cnt) - CW'(w_pop_cnt);
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        (w_push_cnt == 2'd0) || in_ready);
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        r_count <= CW'(DEPTH));
endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: a queue model of the expected FIFO contents is checked every cycle.
// A small regfile model consumes the write ports, and directed scenarios check specific results.
module tb_wb_commit_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  t_rd [3];
    logic [31:0] t_data [3];
    logic [3:0]  t_we [3];
    logic [4:0]  rd1, rd2;
    logic [31:0] wb_data1, wb_data2;
    logic [3:0]  wb_we1, wb_we2;
    logic [31:0] pend_mask;
    logic [3:0]  fifo_count;

    logic [36:0] exp_q[$];
    logic [31:0] regf [32];
    int          n_cmp = 0;
    int          n_err = 0;

    wb_commit_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd0(t_rd[0]), .in_rd1(t_rd[1]), .in_rd2(t_rd[2]),
        .in_data0(t_data[0]), .in_data1(t_data[1]), .in_data2(t_data[2]),
        .in_we0(t_we[0]), .in_we1(t_we[1]), .in_we2(t_we[2]),
        .rd1(rd1), .wb_data1(wb_data1), .wb_we1(wb_we1),
        .rd2(rd2), .wb_data2(wb_data2), .wb_we2(wb_we2),
        .pend_mask(pend_mask), .fifo_count(fifo_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: sampled on the falling edge, model holds the contents before this cycle's edge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            int          sz;
            logic [31:0] pm;
            bit          acc;
            sz = exp_q.size();
            pm = '0;
            foreach (exp_q[k]) pm[exp_q[k][36:32]] = 1'b1;
            check("count", 64'(fifo_count), 64'(sz));
            check("ready", 64'(in_ready), 64'(sz <= DEPTH - 3));
            check("pend", 64'(pend_mask), 64'(pm));
            check("we1", 64'(wb_we1), (sz >= 1) ? 64'd2 : 64'd0);
            check("we2", 64'(wb_we2), (sz >= 2) ? 64'd2 : 64'd0);
            if (sz >= 2) begin
                check("port1", 64'({rd1, wb_data1}), 64'(exp_q[1]));
                check("port2", 64'({rd2, wb_data2}), 64'(exp_q[0]));
            end else if (sz == 1) begin
                check("port1", 64'({rd1, wb_data1}), 64'(exp_q[0]));
            end else begin
                check("port1_idle", 64'({rd1, wb_data1}), 64'd0);
            end
            // consuming regfile: port 1 wins a same-cycle collision
            if (wb_we2 == 4'd2) regf[rd2] = wb_data2;
            if (wb_we1 == 4'd2) regf[rd1] = wb_data1;
            acc = in_valid && (sz <= DEPTH - 3);
            repeat ((sz >= 2) ? 2 : sz) void'(exp_q.pop_front());
            if (acc)
                for (int l = 0; l < 3; l++)
                    if (t_we[l] == 4'd2 && t_rd[l] != 5'd0)
                        exp_q.push_back({t_rd[l], t_data[l]});
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] we);
        t_rd[l] = rd; t_data[l] = d; t_we[l] = we;
    endtask

    task automatic clear_lanes();
        in_valid = 1'b0;
        for (int l = 0; l < 3; l++) set_lane(l, 5'd0, 32'd0, 4'd0);
    endtask

    task automatic wait_empty(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_in_time", 64'(exp_q.size() == 0), 64'd1);
        step();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regf[r] = '0;
        clear_lanes();
        #2;
        check("rst_we1", 64'(wb_we1), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_pend", 64'(pend_mask), 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        step();

        // 1: async reset with 5 entries queued mid-drain
        in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int l = 0; l < 3; l++) set_lane(l, 5'(10 + 3 * b + l), 32'(100 + 3 * b + l), 4'd2);
            step();
        end
        clear_lanes();
        check("t1_count_before", 64'(fifo_count), 64'd5);
        #2 rst = 1'b1;
        #1;
        check("t1_we1", 64'(wb_we1), 64'd0);
        check("t1_we2", 64'(wb_we2), 64'd0);
        check("t1_count", 64'(fifo_count), 64'd0);
        check("t1_pend", 64'(pend_mask), 64'd0);
        check("t1_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #2 rst = 1'b0;
        step();
        check("t1_after_count", 64'(fifo_count), 64'd0);
        check("t1_after_we1", 64'(wb_we1), 64'd0);

        // 2: single write
        in_valid = 1'b1;
        set_lane(0, 5'd5, 32'hDEADBEEF, 4'd2);
        step();
        clear_lanes();
        check("t2_rd1", 64'(rd1), 64'd5);
        check("t2_data1", 64'(wb_data1), 64'hDEADBEEF);
        check("t2_we1", 64'(wb_we1), 64'd2);
        check("t2_we2", 64'(wb_we2), 64'd0);
        check("t2_pend5", 64'(pend_mask[5]), 64'd1);
        step();
        check("t2_pend_clear", 64'(pend_mask), 64'd0);
        check("t2_x5", 64'(regf[5]), 64'hDEADBEEF);

        // 3: same-bundle WAW
        in_valid = 1'b1;
        set_lane(0, 5'd7, 32'd1, 4'd2);
        set_lane(1, 5'd7, 32'd2, 4'd2);
        step();
        clear_lanes();
        check("t3_port1", 64'({rd1, wb_data1}), 64'({5'd7, 32'd2}));
        check("t3_port2", 64'({rd2, wb_data2}), 64'({5'd7, 32'd1}));
        step();
        check("t3_x7", 64'(regf[7]), 64'd2);

        // 4: filtering
        in_valid = 1'b1;
        set_lane(0, 5'd0, 32'h11, 4'd2);
        set_lane(1, 5'd3, 32'h22, 4'd1);
        set_lane(2, 5'd4, 32'h33, 4'd2);
        step();
        clear_lanes();
        check("t4_count", 64'(fifo_count), 64'd1);
        check("t4_rd1", 64'(rd1), 64'd4);
        step();
        check("t4_count_after", 64'(fifo_count), 64'd0);
        check("t4_x3_untouched", 64'(regf[3]), 64'd0);

        // 5: backpressure, all lanes valid for 10 cycles
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int l = 0; l < 3; l++)
                set_lane(l, 5'(((3 * c + l) % 31) + 1), $urandom, 4'd2);
            step();
        end
        clear_lanes();
        wait_empty(40);

        // 6: cross-cycle WAW behind a backlog
        in_valid = 1'b1;
        for (int l = 0; l < 3; l++) set_lane(l, 5'(20 + l), 32'(l), 4'd2);
        step();
        set_lane(0, 5'd23, 32'h3, 4'd2);
        set_lane(1, 5'd9, 32'hAA, 4'd2);
        set_lane(2, 5'd0, 32'h0, 4'd0);
        step();
        clear_lanes();
        in_valid = 1'b1;
        set_lane(0, 5'd9, 32'hBB, 4'd2);
        step();
        clear_lanes();
        check("t6_pend9_set", 64'(pend_mask[9]), 64'd1);
        wait_empty(20);
        check("t6_pend9_clear", 64'(pend_mask[9]), 64'd0);
        check("t6_x9", 64'(regf[9]), 64'hBB);

        // random mix
        for (int c = 0; c < 200; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < 3; l++)
                set_lane(l, 5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) != 0) ? 4'd2 : 4'($urandom_range(0, 15)));
            step();
        end
        clear_lanes();
        wait_empty(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
